// File: rtl/fpu_instr_enc.sv
// Encodes FP requests into RV64 OP-FP words and queues them in a DEPTH-entry FIFO.
// Optional macro FPU_ENC_ILLEGAL_CHK_EN drops op 111 and pulses err instead of enqueueing it.
module fpu_instr_enc #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_rs1,
  input  logic [4:0]               req_rs2,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instruction,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] FMT_D   = 2'b01;
  localparam logic [2:0] RM_DYN  = 3'b111;
  localparam logic [6:0] OP_FP   = 7'b1010011;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the valid of the same interface, and
  // req_ready looks only at registered occupancy, never at instr_ready.

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic          enq;
  logic          illegal;
  logic [4:0]    funct5;
  logic [4:0]    rs2_eff;
  logic [31:0]   enc_word;

  assign req_ready   = (count_q < DEPTH_C);
  assign instr_valid = (count_q != '0);
  assign instruction = instr_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign count       = count_q;

  assign push = req_valid && req_ready;
  assign pop  = instr_valid && instr_ready;

  always_comb begin
    funct5  = 5'b11111;
    rs2_eff = req_rs2;
    case (req_op)
      3'b000: funct5 = 5'b00000;
      3'b001: funct5 = 5'b00001;
      3'b010: funct5 = 5'b00010;
      3'b011: funct5 = 5'b00011;
      3'b100: begin
        funct5  = 5'b01011;
        rs2_eff = 5'b00000;
      end
      3'b101: begin
        funct5  = 5'b11000;
        rs2_eff = 5'b00010;
      end
      3'b110: begin
        funct5  = 5'b11010;
        rs2_eff = 5'b00010;
      end
      default: begin
        funct5  = 5'b11111;
        rs2_eff = req_rs2;
      end
    endcase
  end

  assign enc_word = {funct5, FMT_D, rs2_eff, req_rs1, RM_DYN, req_rd, OP_FP};
  assign illegal  = push && (req_op == 3'b111);

`ifdef FPU_ENC_ILLEGAL_CHK_EN
  logic err_q, err_d;

  assign enq = push && !illegal;

  always_comb begin
    err_d = illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Op 111 is encoded with funct5 11111 and queued like any other request.
  assign enq = push || illegal;
  assign err = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (enq) begin
      mem_d[wr_ptr_q] = enc_word;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not cleared on reset; the zeroed count hides stale entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fpu_instr_enc.sv
// Directed bench for fpu_instr_enc: encodings, FIFO ordering, full/backpressure, reset, illegal op.
module tb_fpu_instr_enc;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [2:0]  count;
  logic        err;

  int checks = 0;
  int errors = 0;

  fpu_instr_enc #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .count       (count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
    req_valid = 1'b1;
    req_op    = op;
    req_rd    = rd;
    req_rs1   = rs1;
    req_rs2   = rs2;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_rd    = 5'd0;
    req_rs1   = 5'd0;
    req_rs2   = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_req();
    instr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    checks++;
    if (instr_valid !== 1'b0 || instruction !== 32'h0) begin
      errors++; $display("FAIL reset_out: got valid=%b instr=%h expected 0/00000000", instr_valid, instruction);
    end
    checks++;
    if (req_ready !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL reset_ready_err: got ready=%b err=%b expected 1/0", req_ready, err);
    end
  endtask

  task automatic test_add();
    instr_ready = 1'b0;
    set_req(3'b000, 5'd1, 5'd2, 5'd3);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL add_no_bypass: got valid=%b expected 0", instr_valid);
    end
    step();
    idle_req();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== 32'h023170d3 || count !== 3'd1) begin
      errors++; $display("FAIL add_word: got valid=%b instr=%h count=%0d expected 1/023170d3/1",
                         instr_valid, instruction, count);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0 || instruction !== 32'h0) begin
      errors++; $display("FAIL add_pop: got count=%0d valid=%b instr=%h expected 0/0/00000000",
                         count, instr_valid, instruction);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL pop_empty: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_sqrt_cvt();
    instr_ready = 1'b1;
    set_req(3'b100, 5'd23, 5'd3, 5'd9);
    step();
    checks++;
    if (instruction !== 32'h5a01fbd3 || count !== 3'd1) begin
      errors++; $display("FAIL sqrt_word: got instr=%h count=%0d expected 5a01fbd3/1", instruction, count);
    end
    set_req(3'b101, 5'd19, 5'd11, 5'd31);
    step();
    idle_req();
    checks++;
    if (instruction !== 32'hc225f9d3 || count !== 3'd1) begin
      errors++; $display("FAIL cvt_word: got instr=%h count=%0d expected c225f9d3/1", instruction, count);
    end
    step();
    instr_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL cvt_drain: got count=%0d valid=%b expected 0/0", count, instr_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_words [5];
    logic [2:0]  exp_cnt   [5];
    exp_words[0] = 32'h127372d3;
    exp_words[1] = 32'h023170d3;
    exp_words[2] = 32'h0ada75d3;
    exp_words[3] = 32'h1af87f53;
    exp_words[4] = 32'h5a01fbd3;
    exp_cnt[0] = 3'd3; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd2; exp_cnt[3] = 3'd1; exp_cnt[4] = 3'd0;
    instr_ready = 1'b0;
    set_req(3'b010, 5'd5, 5'd6, 5'd7);
    step();
    set_req(3'b000, 5'd1, 5'd2, 5'd3);
    step();
    set_req(3'b001, 5'd11, 5'd20, 5'd13);
    step();
    set_req(3'b011, 5'd30, 5'd16, 5'd15);
    step();
    checks++;
    if (count !== 3'd4 || req_ready !== 1'b0) begin
      errors++; $display("FAIL full: got count=%0d ready=%b expected 4/0", count, req_ready);
    end
    set_req(3'b100, 5'd23, 5'd3, 5'd9);
    step();
    checks++;
    if (count !== 3'd4 || instruction !== exp_words[0]) begin
      errors++; $display("FAIL full_hold: got count=%0d instr=%h expected 4/%h", count, instruction, exp_words[0]);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instruction !== exp_words[i]) begin
        errors++; $display("FAIL order_%0d: got %h expected %h", i, instruction, exp_words[i]);
      end
      step();
      if (i == 1) idle_req();
      checks++;
      if (count !== exp_cnt[i]) begin
        errors++; $display("FAIL order_count_%0d: got %0d expected %0d", i, count, exp_cnt[i]);
      end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_illegal();
    instr_ready = 1'b0;
    set_req(3'b111, 5'd4, 5'd5, 5'd6);
    step();
    idle_req();
`ifdef FPU_ENC_ILLEGAL_CHK_EN
    checks++;
    if (err !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL illegal_err: got err=%b count=%0d expected 1/0", err, count);
    end
    step();
    checks++;
    if (err !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL illegal_err_end: got err=%b count=%0d expected 0/0", err, count);
    end
`else
    checks++;
    if (instruction !== 32'hfa62f253 || count !== 3'd1 || err !== 1'b0) begin
      errors++; $display("FAIL illegal_word: got instr=%h count=%0d err=%b expected fa62f253/1/0",
                         instruction, count, err);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL illegal_drain: got count=%0d err=%b expected 0/0", count, err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    set_req(3'b000, 5'd1, 5'd2, 5'd3);
    step();
    set_req(3'b001, 5'd11, 5'd20, 5'd13);
    step();
    set_req(3'b011, 5'd30, 5'd16, 5'd15);
    step();
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL mid_fill: got count=%0d expected 3", count);
    end
    rst = 1'b1;
    instr_ready = 1'b1;
    set_req(3'b010, 5'd5, 5'd6, 5'd7);
    step();
    rst = 1'b0;
    instr_ready = 1'b0;
    idle_req();
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0 || instruction !== 32'h0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got count=%0d valid=%b instr=%h ready=%b expected 0/0/00000000/1",
                         count, instr_valid, instruction, req_ready);
    end
    set_req(3'b010, 5'd5, 5'd6, 5'd7);
    step();
    idle_req();
    checks++;
    if (count !== 3'd1 || instruction !== 32'h127372d3) begin
      errors++; $display("FAIL post_reset_push: got count=%0d instr=%h expected 1/127372d3", count, instruction);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_sub_div();
    instr_ready = 1'b0;
    set_req(3'b001, 5'd11, 5'd20, 5'd13);
    step();
    set_req(3'b011, 5'd30, 5'd16, 5'd15);
    step();
    idle_req();
    checks++;
    if (instruction !== 32'h0ada75d3 || count !== 3'd2) begin
      errors++; $display("FAIL sub_word: got instr=%h count=%0d expected 0ada75d3/2", instruction, count);
    end
    instr_ready = 1'b1;
    step();
    checks++;
    if (instruction !== 32'h1af87f53 || count !== 3'd1) begin
      errors++; $display("FAIL div_word: got instr=%h count=%0d expected 1af87f53/1", instruction, count);
    end
    step();
    instr_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || instruction !== 32'h0) begin
      errors++; $display("FAIL sub_div_drain: got count=%0d instr=%h expected 0/00000000", count, instruction);
    end
  endtask

  initial begin
    rst = 1'b1;
    instr_ready = 1'b0;
    idle_req();
    test_reset();
    test_add();
    test_sqrt_cvt();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_sub_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
